// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the load-use / redirect interlock.
// FSM encoding, register-zero constant and counter sizing helper.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  localparam int REG_ZERO = 0;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_match.sv
// Load-use compare between the EXE load destination and ID sources.
// Register zero never produces a hit.
module hazard_match
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] exe_rt,
  input  logic              exe_mem_read,
  output logic              hit
);

  logic rs_hit;
  logic rt_hit;
  logic nz;

  assign nz     = exe_rt != REG_AW'(REG_ZERO);
  assign rs_hit = id_rs_used && (id_rs == exe_rt);
  assign rt_hit = id_rt_used && (id_rt == exe_rt);
  assign hit    = exe_mem_read && nz && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: load-use stall sequencing and IF/ID redirect flush.
// Optional perf counters when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W    = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] exe_rt,
  input  logic              exe_mem_read,
  input  logic              mem_wait,
  input  logic              if_flush,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              ctrl_bubble,
  output logic              stall_active
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  localparam int LW = cnt_w(LOAD_LAT);
  localparam int FW = cnt_w(FLUSH_CYC);

  state_e          state;
  logic [LW-1:0]   cnt;
  logic [FW-1:0]   fcnt;
  logic            hit;

  hazard_match #(
    .REG_AW(REG_AW)
  ) u_match (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .exe_rt      (exe_rt),
    .exe_mem_read(exe_mem_read),
    .hit         (hit)
  );

  // Redirect outranks everything; hazards are ignored while flushing.
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    ctrl_bubble  = 1'b1;
    stall_active = 1'b0;
    if (rst_n) begin
      stall_active = state != ST_RUN;
      priority case (1'b1)
        if_flush, state == ST_FLUSH: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end
        state == ST_LD_STALL, hit: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
        end
        default: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ctrl_bubble = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
      fcnt  <= '0;
    end else if (if_flush) begin
      cnt <= '0;
      if (FLUSH_CYC > 1) begin
        state <= ST_FLUSH;
        fcnt  <= FW'(FLUSH_CYC - 1);
      end else begin
        state <= ST_RUN;
      end
    end else begin
      unique case (state)
        ST_RUN: begin
          if (hit && LOAD_LAT > 1) begin
            state <= ST_LD_STALL;
            cnt   <= LW'(LOAD_LAT - 1);
          end
        end
        ST_LD_STALL: begin
          if (!mem_wait) begin
            if (cnt == LW'(1)) state <= ST_RUN;
            cnt <= cnt - 1'b1;
          end
        end
        ST_FLUSH: begin
          if (fcnt == FW'(1)) state <= ST_RUN;
          fcnt <= fcnt - 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  // Out of reset, pc_write low can only mean a load stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (if_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
